// File: rtl/debouncer_multi_if.sv
// Button-side bus of the multi-channel debouncer: sample strobe and raw pads in,
// clean level and event pulses out.
interface debouncer_multi_if #(
  parameter int unsigned N_CH = 4
) ();
  logic            tick;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] long_press;

  modport master (
    output tick, btn,
    input  level, rise, fall, toggle, long_press
  );

  modport slave (
    input  tick, btn,
    output level, rise, fall, toggle, long_press
  );
endinterface

// File: rtl/debouncer_multi.sv
// N-channel debouncer: 2-flop synchroniser, DEPTH-deep sample window with hysteresis,
// rise/fall pulses, press toggle and a one-shot long-press pulse per channel.
module debouncer_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned HOLD_TICKS = 1000
) (
  input  logic              msclk,
  input  logic              rst,
  debouncer_multi_if.slave  dbus
);

  // HOLD_TICKS=0 would give a zero-width counter; keep one bit that never moves.
  localparam int unsigned   CW       = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [DEPTH-1:0] win_q [N_CH];
  logic [DEPTH-1:0] win_d [N_CH];
  logic [CW-1:0]    cnt_q [N_CH];
  logic [CW-1:0]    cnt_d [N_CH];
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [N_CH-1:0]  toggle_q, toggle_d;
  logic [N_CH-1:0]  lp_q, lp_d;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      level_d[i]  = level_q[i];
      rise_d[i]   = 1'b0;
      fall_d[i]   = 1'b0;
      toggle_d[i] = toggle_q[i];
      lp_d[i]     = 1'b0;
      cnt_d[i]    = cnt_q[i];
      win_d[i]    = dbus.tick ? {win_q[i][DEPTH-2:0], sync2_q[i]} : win_q[i];

      if ((&win_q[i]) && !level_q[i]) begin
        level_d[i]  = 1'b1;
        rise_d[i]   = 1'b1;
        toggle_d[i] = ~toggle_q[i];
      end else if (!(|win_q[i]) && level_q[i]) begin
        level_d[i]  = 1'b0;
        fall_d[i]   = 1'b1;
      end

      // Counting starts the tick after the rise edge; saturation gives one pulse per press.
      if (!level_d[i]) begin
        cnt_d[i] = '0;
      end else if (dbus.tick && level_q[i] && (cnt_q[i] != HOLD_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        lp_d[i]  = (HOLD_TICKS != 0) && (cnt_q[i] == HOLD_MAX - 1'b1);
      end
    end
  end

  always_ff @(posedge msclk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
      lp_q     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        win_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= dbus.btn;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      lp_q     <= lp_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dbus.level      = level_q;
  assign dbus.rise       = rise_q;
  assign dbus.fall       = fall_q;
  assign dbus.toggle     = toggle_q;
  assign dbus.long_press = lp_q;

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised N-channel push-button debouncer and edge/event generator for the board button and switch inputs. Each raw input is sampled on a shared sample strobe through a DEPTH-deep shift window.
- Per channel it produces:
  - a clean level;
  - one-cycle rise and fall pulses;
  - a press-toggled latch;
  - a one-shot long-press pulse.
- It replaces the single-channel, fixed-depth, toggle-only debouncer. It sits between the raw pad inputs and the control FSMs.

Parameters:
- N_CH, 4, number of independent channels (≥1).
- DEPTH, 10, consecutive identical samples required to accept a new level (≥2).
- HOLD_TICKS, 1000, sample ticks of stable-high level before long_press fires. 0 disables long_press (output tied 0).

Ports:
- msclk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  sample strobe (e.g. 1 kHz enable, one msclk wide). Tie to 1 to sample every clock.
- btn  in  N_CH  raw, asynchronous button inputs.
- level  out  N_CH  debounced level.
- rise  out  N_CH  one-cycle pulse when level goes 0→1.
- fall  out  N_CH  one-cycle pulse when level goes 1→0.
- toggle  out  N_CH  flips on every accepted press (on rise).
- long_press  out  N_CH  one-cycle pulse when a press has been held HOLD_TICKS ticks.

Behaviour:
- Reset (rst=1 at an edge):
  - all shift windows, level, toggle and hold counters cleared to 0;
  - rise, fall and long_press are 0 on the following cycle.
  - Reset overrides tick and btn. Reset mid-press discards the press: no rise/fall is generated at reset release.
- Input synchronisation: each btn[i] passes through a 2-flop synchroniser every msclk, independent of tick. The synchronised value is btn_s[i].
- Sampling: on an edge with tick=1, the window shifts as win[i] <= {win[i][DEPTH-2:0], btn_s[i]}. With tick=0 the window holds.
- Acceptance is evaluated every msclk on the registered window:
  - win all-ones and level=0 → level<=1, rise<=1, toggle<=~toggle;
  - win all-zeros and level=1 → level<=0, fall<=1;
  - any mixed window → level holds (hysteresis). Glitches shorter than DEPTH samples never change level.
- Pulses: rise, fall and long_press are high for exactly one msclk. Otherwise 0. Rise and fall are never simultaneous on a channel.
- Latency (tick every clock): input change → level change = 2 (synchroniser) + DEPTH (window fill) + 1 (acceptance) msclk edges, i.e. DEPTH+3. rise/fall assert on the same edge as the level change.
- Long press:
  - Per-channel counter, width clog2(HOLD_TICKS+1). It increments on tick while level=1 and saturates at HOLD_TICKS.
  - long_press pulses on the edge the counter reaches HOLD_TICKS; it fires once per press.
  - The counter clears when level=0 (including the fall edge). A new press restarts it.
- Channel independence: no state is shared except tick. Simultaneous events on different channels are all reported in the same cycle.
- Power-up: windows and level start at 0. A button held during/after reset produces a rise DEPTH+3 ticks after reset release.

Test Plan:
- Params N_CH=2, DEPTH=4, HOLD_TICKS=8, tick=1 for all scenarios unless stated.
- Reset values: assert rst 3 cycles with btn=2'b11 → level/rise/fall/toggle/long_press all 0 during reset. After release, level[0] and level[1] rise at cycle 7 (DEPTH+3), with one rise pulse each.
- Glitch rejection: btn[0] high for 3 cycles then low → level[0], rise[0] and toggle[0] stay 0.
- Clean press/release: btn[0] high 20 cycles then low → rise[0] at cycle 7 and toggle[0]=1. fall[0] comes 7 cycles after release; toggle stays 1. A second press → toggle[0]=0.
- Long press: btn[1] held 30 cycles → long_press[1] one pulse exactly 8 cycles after rise[1], and no further pulse while held. Release then press 5 cycles → no long_press.
- Tick gating: tick every 4th cycle, btn[0] high → level[0] rises only after 4 ticks have shifted (within 16+3 cycles). Holding tick=0 with btn toggling → level unchanged.
- Reset mid-press: btn[0] held, level[0]=1 and counter=5, assert rst 1 cycle → level[0]=0, counter=0, no fall pulse. Rise reappears DEPTH+3 cycles later; long_press occurs 8 ticks after that rise.
